// File: rtl/gt_link_ctrl.sv
// GT bring-up and link-supervision FSM in the init clock domain.
// Sequences full/RX-only GT resets with timeouts, bounded retries and link qualification.
module gt_link_ctrl #(
   parameter int unsigned RST_PULSE_CYCLES = 128,
   parameter int unsigned TX_TIMEOUT       = 2000000,
   parameter int unsigned RX_TIMEOUT       = 4000000,
   parameter int unsigned LINKUP_STABLE    = 1024,
   parameter int unsigned MAX_RX_RETRIES   = 4,
   parameter int unsigned RETRY_W          = 8
) (
   input  logic               init_clk,
   input  logic               rst,
   input  logic               tx_good,
   input  logic               rx_good,
   output logic               gt_reset_all,
   output logic               gt_rx_reset,
   output logic               link_up,
   output logic [RETRY_W-1:0] retry_cnt,
   output logic [2:0]         state_o
);

   localparam int unsigned TMax0    = (TX_TIMEOUT > RX_TIMEOUT) ? TX_TIMEOUT : RX_TIMEOUT;
   localparam int unsigned TMax     = (TMax0 > RST_PULSE_CYCLES) ? TMax0 : RST_PULSE_CYCLES;
   localparam int unsigned TimerW   = (TMax > 1) ? $clog2(TMax) : 1;
   localparam int unsigned StableW  = (LINKUP_STABLE > 1) ? $clog2(LINKUP_STABLE) : 1;
   localparam int unsigned RxRetryW = $clog2(MAX_RX_RETRIES + 1);

   typedef logic [TimerW-1:0]   timer_t;
   typedef logic [StableW-1:0]  stable_t;
   typedef logic [RxRetryW-1:0] rx_retry_t;

   localparam timer_t    RstLast     = timer_t'(RST_PULSE_CYCLES - 1);
   localparam timer_t    TxLast      = timer_t'(TX_TIMEOUT - 1);
   localparam timer_t    RxLast      = timer_t'(RX_TIMEOUT - 1);
   localparam stable_t   StableLast  = stable_t'(LINKUP_STABLE - 1);
   localparam rx_retry_t RxRetryLast = rx_retry_t'(MAX_RX_RETRIES - 1);

   typedef enum logic [2:0] {
      StRst    = 3'd0,
      StWaitTx = 3'd1,
      StWaitRx = 3'd2,
      StRxRst  = 3'd3,
      StUp     = 3'd4
   } state_e;

   state_e    state_q, state_d;
   timer_t    timer_q, timer_d;
   stable_t   stable_q, stable_d;
   rx_retry_t rx_retry_q, rx_retry_d;
   logic      retry_inc;

   always_comb begin
      state_d    = state_q;
      timer_d    = timer_q;
      stable_d   = stable_q;
      rx_retry_d = rx_retry_q;
      retry_inc  = 1'b0;
      case (state_q)
         StRst: begin
            if (timer_q == RstLast) begin
               state_d    = StWaitTx;
               timer_d    = '0;
               rx_retry_d = '0;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         StWaitTx: begin
            if (tx_good) begin
               state_d  = StWaitRx;
               timer_d  = '0;
               stable_d = '0;
            end else if (timer_q == TxLast) begin
               state_d   = StRst;
               timer_d   = '0;
               retry_inc = 1'b1;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         StWaitRx: begin
            if (!tx_good) begin
               state_d   = StRst;
               timer_d   = '0;
               retry_inc = 1'b1;
            end else if (rx_good && stable_q == StableLast) begin
               // Qualification beats a timeout expiring in the same cycle.
               state_d    = StUp;
               timer_d    = '0;
               rx_retry_d = '0;
            end else if (timer_q == RxLast) begin
               timer_d   = '0;
               retry_inc = 1'b1;
               if (rx_retry_q >= RxRetryLast) begin
                  state_d = StRst;
               end else begin
                  state_d    = StRxRst;
                  rx_retry_d = rx_retry_q + 1'b1;
               end
            end else begin
               timer_d  = timer_q + 1'b1;
               stable_d = rx_good ? stable_q + 1'b1 : '0;
            end
         end
         StRxRst: begin
            if (!tx_good) begin
               state_d   = StRst;
               timer_d   = '0;
               retry_inc = 1'b1;
            end else if (timer_q == RstLast) begin
               state_d  = StWaitRx;
               timer_d  = '0;
               stable_d = '0;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         StUp: begin
            if (!tx_good) begin
               state_d   = StRst;
               timer_d   = '0;
               retry_inc = 1'b1;
            end else if (!rx_good) begin
               state_d    = StRxRst;
               timer_d    = '0;
               rx_retry_d = rx_retry_t'(1);
               retry_inc  = 1'b1;
            end
         end
         default: begin
            state_d = StRst;
            timer_d = '0;
         end
      endcase
   end

   // Outputs decode the next state so they change together with state_q.
   always_ff @(posedge init_clk or posedge rst) begin
      if (rst) begin
         state_q      <= StRst;
         timer_q      <= '0;
         stable_q     <= '0;
         rx_retry_q   <= '0;
         gt_reset_all <= 1'b1;
         gt_rx_reset  <= 1'b0;
         link_up      <= 1'b0;
         retry_cnt    <= '0;
      end else begin
         state_q      <= state_d;
         timer_q      <= timer_d;
         stable_q     <= stable_d;
         rx_retry_q   <= rx_retry_d;
         gt_reset_all <= (state_d == StRst);
         gt_rx_reset  <= (state_d == StRxRst);
         link_up      <= (state_d == StUp);
         if (retry_inc && retry_cnt != '1) begin
            retry_cnt <= retry_cnt + 1'b1;
         end
      end
   end

   assign state_o = state_q;

endmodule

// File: tb/tb_gt_link_ctrl.sv
// Directed bench for gt_link_ctrl with small timing parameters.
// Cycle k is sampled at the negedge after the k-th posedge following reset release.
module tb_gt_link_ctrl;

   logic       init_clk;
   logic       rst;
   logic       tx_good;
   logic       rx_good;
   logic       gt_reset_all;
   logic       gt_rx_reset;
   logic       link_up;
   logic [7:0] retry_cnt;
   logic [2:0] state_o;

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;

   gt_link_ctrl #(
      .RST_PULSE_CYCLES (4),
      .TX_TIMEOUT       (16),
      .RX_TIMEOUT       (32),
      .LINKUP_STABLE    (8),
      .MAX_RX_RETRIES   (2),
      .RETRY_W          (8)
   ) dut (
      .init_clk     (init_clk),
      .rst          (rst),
      .tx_good      (tx_good),
      .rx_good      (rx_good),
      .gt_reset_all (gt_reset_all),
      .gt_rx_reset  (gt_rx_reset),
      .link_up      (link_up),
      .retry_cnt    (retry_cnt),
      .state_o      (state_o)
   );

   initial init_clk = 1'b0;
   always #5 init_clk = ~init_clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s at cycle %0d: got %0d, expected %0d", tag, cyc, got, exp);
      end
   endtask

   task automatic do_reset(input logic tx, input logic rx);
      rst     = 1'b1;
      tx_good = tx;
      rx_good = rx;
      @(negedge init_clk);
      @(negedge init_clk);
      rst = 1'b0;
      cyc = 0;
   endtask

   task automatic goto(input int c);
      while (cyc < c) begin
         @(negedge init_clk);
         cyc++;
      end
   endtask

   initial begin
      rst     = 1'b1;
      tx_good = 1'b0;
      rx_good = 1'b0;

      // Clean bring-up, then link drops.
      do_reset(1'b0, 1'b0);
      check_eq("rst_state", 32'(state_o), 0);
      check_eq("rst_gra", 32'(gt_reset_all), 1);
      check_eq("rst_rxr", 32'(gt_rx_reset), 0);
      check_eq("rst_lu", 32'(link_up), 0);
      check_eq("rst_retry", 32'(retry_cnt), 0);
      goto(3);  check_eq("up_gra_c3", 32'(gt_reset_all), 1);
      goto(4);  check_eq("up_gra_c4", 32'(gt_reset_all), 0);
                check_eq("up_state_c4", 32'(state_o), 1);
      goto(6);  tx_good = 1'b1;
      goto(7);  check_eq("up_state_c7", 32'(state_o), 2);
      goto(10); rx_good = 1'b1;
      goto(17); check_eq("up_lu_c17", 32'(link_up), 0);
      goto(18); check_eq("up_lu_c18", 32'(link_up), 1);
                check_eq("up_state_c18", 32'(state_o), 4);
                check_eq("up_retry", 32'(retry_cnt), 0);
      goto(20); rx_good = 1'b0;
      goto(21); rx_good = 1'b1;
                check_eq("drop_lu", 32'(link_up), 0);
                check_eq("drop_rxr", 32'(gt_rx_reset), 1);
                check_eq("drop_retry", 32'(retry_cnt), 1);
      goto(24); check_eq("drop_rxr_c24", 32'(gt_rx_reset), 1);
      goto(25); check_eq("drop_rxr_c25", 32'(gt_rx_reset), 0);
                check_eq("drop_state_c25", 32'(state_o), 2);
      goto(32); check_eq("relink_lu_c32", 32'(link_up), 0);
      goto(33); check_eq("relink_lu_c33", 32'(link_up), 1);
      goto(40); tx_good = 1'b0; rx_good = 1'b0;
      goto(41); check_eq("txdrop_state", 32'(state_o), 0);
                check_eq("txdrop_gra", 32'(gt_reset_all), 1);
                check_eq("txdrop_lu", 32'(link_up), 0);
                check_eq("txdrop_retry", 32'(retry_cnt), 2);

      // TX timeout: full reset every 20 cycles.
      do_reset(1'b0, 1'b0);
      goto(19); check_eq("txto_gra_c19", 32'(gt_reset_all), 0);
                check_eq("txto_retry_c19", 32'(retry_cnt), 0);
      goto(20); check_eq("txto_gra_c20", 32'(gt_reset_all), 1);
                check_eq("txto_retry_c20", 32'(retry_cnt), 1);
      goto(23); check_eq("txto_gra_c23", 32'(gt_reset_all), 1);
      goto(24); check_eq("txto_gra_c24", 32'(gt_reset_all), 0);
      goto(40); check_eq("txto_retry_c40", 32'(retry_cnt), 2);
                check_eq("txto_gra_c40", 32'(gt_reset_all), 1);
      goto(60); check_eq("txto_retry_c60", 32'(retry_cnt), 3);

      // RX escalation: one RX reset, then full reset.
      do_reset(1'b1, 1'b0);
      goto(5);  check_eq("rxe_state_c5", 32'(state_o), 2);
      goto(36); check_eq("rxe_rxr_c36", 32'(gt_rx_reset), 0);
      goto(37); check_eq("rxe_rxr_c37", 32'(gt_rx_reset), 1);
                check_eq("rxe_retry_c37", 32'(retry_cnt), 1);
                check_eq("rxe_gra_c37", 32'(gt_reset_all), 0);
      goto(40); check_eq("rxe_rxr_c40", 32'(gt_rx_reset), 1);
      goto(41); check_eq("rxe_rxr_c41", 32'(gt_rx_reset), 0);
                check_eq("rxe_state_c41", 32'(state_o), 2);
      goto(72); check_eq("rxe_gra_c72", 32'(gt_reset_all), 0);
      goto(73); check_eq("rxe_gra_c73", 32'(gt_reset_all), 1);
                check_eq("rxe_state_c73", 32'(state_o), 0);
                check_eq("rxe_retry_c73", 32'(retry_cnt), 2);

      // Async reset mid RX reset pulse.
      do_reset(1'b1, 1'b0);
      goto(38); check_eq("arst_pre_rxr", 32'(gt_rx_reset), 1);
                check_eq("arst_pre_retry", 32'(retry_cnt), 1);
      #2 rst = 1'b1;
      #1;
      check_eq("arst_rxr", 32'(gt_rx_reset), 0);
      check_eq("arst_gra", 32'(gt_reset_all), 1);
      check_eq("arst_state", 32'(state_o), 0);
      check_eq("arst_retry", 32'(retry_cnt), 0);

      // Stability glitch restarts qualification.
      do_reset(1'b1, 1'b0);
      goto(5);  rx_good = 1'b1;
      goto(10); rx_good = 1'b0;
      goto(11); rx_good = 1'b1;
      goto(13); check_eq("glitch_lu_c13", 32'(link_up), 0);
      goto(18); check_eq("glitch_lu_c18", 32'(link_up), 0);
      goto(19); check_eq("glitch_lu_c19", 32'(link_up), 1);

      // Retry counter saturation.
      do_reset(1'b0, 1'b0);
      goto(5099); check_eq("sat_c5099", 32'(retry_cnt), 254);
      goto(5100); check_eq("sat_c5100", 32'(retry_cnt), 255);
      goto(6004); check_eq("sat_c6004", 32'(retry_cnt), 255);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
